// File: rtl/readout_sequencer.sv
// readout_sequencer
// Multi-source trigger arbiter and readout frame sequencer for the chip/ADC
// readout path. Rising edges on masked trigger sources are queued (up to
// PENDING_DEPTH deep). Each queued trigger launches one frame, which has three
// phases: an optional pre-delay, then N read-clock enables, then an optional
// holdoff. All outputs that leave the block are registered, except busy.
// busy is a plain OR of registered state and carries no extra logic.
module readout_sequencer #(
  parameter int N_TRIG_SRC             = 2,
  parameter int TRIGGER_COUNTER_LENGTH = 16,
  parameter int NUM_DATA_W             = 13,
  parameter int DELAY_W                = 8,
  parameter int PENDING_DEPTH          = 4,
  localparam int PEND_W                = $clog2(PENDING_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [N_TRIG_SRC-1:0]             trig_in,
  input  logic [N_TRIG_SRC-1:0]             trig_mask,
  input  logic [NUM_DATA_W-1:0]             cfg_num_data,
  input  logic [DELAY_W-1:0]                cfg_pre_delay,
  input  logic [DELAY_W-1:0]                cfg_holdoff,
  input  logic                              counter_clear,
  output logic                              chip_read_clk_en,
  output logic                              adc_read_en,
  output logic                              frame_start,
  output logic                              frame_end,
  output logic                              busy,
  output logic [PEND_W-1:0]                 pending_count,
  output logic [TRIGGER_COUNTER_LENGTH-1:0] trig_counter,
  output logic [TRIGGER_COUNTER_LENGTH-1:0] lost_counter
);

  // One shared phase counter covers both the delays and the read length.
  localparam int CNT_W = (NUM_DATA_W > DELAY_W) ? NUM_DATA_W : DELAY_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_READ,
    S_HOLDOFF
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_DATA_W-1:0]   lat_num;
  logic [DELAY_W-1:0]      lat_pre;
  logic [DELAY_W-1:0]      lat_holdoff;
  logic [N_TRIG_SRC-1:0]   prev_trig;

  logic                    trig_edge;
  logic                    launch;
  logic                    accept;
  logic [PEND_W-1:0]       pend_after_launch;
  logic [CNT_W-1:0]        pre_last;
  logic [CNT_W-1:0]        read_last;
  logic [CNT_W-1:0]        holdoff_last;

  // Several sources rising in the same cycle collapse into a single trigger.
  assign trig_edge = |(trig_in & ~prev_trig & trig_mask);

  // A launch frees a queue slot in the same cycle, so a full queue can still
  // accept a trigger when a frame is being launched.
  assign launch            = (state == S_IDLE) && (pending_count != '0);
  assign pend_after_launch = pending_count - PEND_W'(launch);
  assign accept            = trig_edge && (pend_after_launch < PEND_W'(PENDING_DEPTH));

  // Terminal counts for each phase, taken from the values latched at launch.
  assign pre_last     = CNT_W'(lat_pre) - CNT_W'(1);
  assign read_last    = CNT_W'(lat_num) - CNT_W'(1);
  assign holdoff_last = CNT_W'(lat_holdoff) - CNT_W'(1);

  assign busy = (state != S_IDLE) || (pending_count != '0);

  // Trigger edge history, pending queue depth and the two statistics counters.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_trig     <= '0;
      pending_count <= '0;
      trig_counter  <= '0;
      lost_counter  <= '0;
    end else begin
      prev_trig     <= trig_in;
      pending_count <= pend_after_launch + PEND_W'(accept);
      if (counter_clear) begin
        trig_counter <= '0;
        lost_counter <= '0;
      end else if (accept) begin
        trig_counter <= trig_counter + TRIGGER_COUNTER_LENGTH'(1);
      end else if (trig_edge && (lost_counter != '1)) begin
        lost_counter <= lost_counter + TRIGGER_COUNTER_LENGTH'(1);
      end
    end
  end

  // Frame FSM: launches queued triggers and drives the registered enables and markers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      cnt              <= '0;
      lat_num          <= '0;
      lat_pre          <= '0;
      lat_holdoff      <= '0;
      chip_read_clk_en <= 1'b0;
      adc_read_en      <= 1'b0;
      frame_start      <= 1'b0;
      frame_end        <= 1'b0;
    end else begin
      // NOTE: the pulse outputs default low each cycle and are raised only on
      // the transition that needs them, so they can never stick high.
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      adc_read_en <= chip_read_clk_en;
      case (state)
        S_IDLE: begin
          if (launch) begin
            // Configuration is frozen for the whole frame.
            lat_num     <= (cfg_num_data == '0) ? NUM_DATA_W'(1) : cfg_num_data;
            lat_pre     <= cfg_pre_delay;
            lat_holdoff <= cfg_holdoff;
            cnt         <= '0;
            if (cfg_pre_delay != '0) begin
              state <= S_PRE;
            end else begin
              state            <= S_READ;
              chip_read_clk_en <= 1'b1;
              frame_start      <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (cnt == pre_last) begin
            cnt              <= '0;
            state            <= S_READ;
            chip_read_clk_en <= 1'b1;
            frame_start      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          if (cnt == read_last) begin
            // The last ADC cycle follows this edge, one cycle behind the enable.
            cnt              <= '0;
            chip_read_clk_en <= 1'b0;
            frame_end        <= 1'b1;
            state            <= (lat_holdoff != '0) ? S_HOLDOFF : S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (cnt == holdoff_last) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state            <= S_IDLE;
          cnt              <= '0;
          chip_read_clk_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer
// Directed bench for readout_sequencer. A schedule-level model predicts every
// output on every cycle. Literal expectations pin the frame timing and the
// counter behaviour.
module tb_readout_sequencer;

  localparam int N_SRC = 2;
  // Narrow counters so that wrap and saturation are reached in a short run.
  localparam int TCL   = 8;
  localparam int NDW   = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N_SRC-1:0] trig_in = '0;
  logic [N_SRC-1:0] trig_mask = '0;
  logic [NDW-1:0]   cfg_num_data = '0;
  logic [DW-1:0]    cfg_pre_delay = '0;
  logic [DW-1:0]    cfg_holdoff = '0;
  logic             counter_clear = 1'b0;
  logic             chip_read_clk_en;
  logic             adc_read_en;
  logic             frame_start;
  logic             frame_end;
  logic             busy;
  logic [PW-1:0]    pending_count;
  logic [TCL-1:0]   trig_counter;
  logic [TCL-1:0]   lost_counter;

  readout_sequencer #(
    .N_TRIG_SRC             (N_SRC),
    .TRIGGER_COUNTER_LENGTH (TCL),
    .NUM_DATA_W             (NDW),
    .DELAY_W                (DW),
    .PENDING_DEPTH          (DEPTH)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .trig_in          (trig_in),
    .trig_mask        (trig_mask),
    .cfg_num_data     (cfg_num_data),
    .cfg_pre_delay    (cfg_pre_delay),
    .cfg_holdoff      (cfg_holdoff),
    .counter_clear    (counter_clear),
    .chip_read_clk_en (chip_read_clk_en),
    .adc_read_en      (adc_read_en),
    .frame_start      (frame_start),
    .frame_end        (frame_end),
    .busy             (busy),
    .pending_count    (pending_count),
    .trig_counter     (trig_counter),
    .lost_counter     (lost_counter)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the frame schedule is derived from the launch cycle L.
  //   en high on cycles [L+pre, L+pre+N-1], adc one cycle later,
  //   machine busy until cycle L+pre+N+holdoff, next launch no earlier than
  //   the cycle after that. Cycle index e counts clock edges since reset.
  // ---------------------------------------------------------------------------
  int             e_idx = 0;
  int             busy_until = 0;
  int             m_pend = 0;
  logic [N_SRC-1:0] m_prev = '0;
  logic [TCL-1:0] m_trig = '0;
  logic [TCL-1:0] m_lost = '0;
  bit             have_frame = 0;
  int             f_s = 0;
  int             f_n = 0;
  bit             m_edge;
  bit             m_launch;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      e_idx = 0; busy_until = 0; m_pend = 0; m_prev = '0;
      m_trig = '0; m_lost = '0; have_frame = 0; f_s = 0; f_n = 0;
    end else begin
      e_idx    = e_idx + 1;
      m_edge   = |(trig_in & ~m_prev & trig_mask);
      m_prev   = trig_in;
      m_launch = (e_idx - 1 >= busy_until) && (m_pend > 0);
      if (m_launch) begin
        f_n        = (cfg_num_data == '0) ? 1 : int'(cfg_num_data);
        f_s        = e_idx + int'(cfg_pre_delay);
        busy_until = f_s + f_n + int'(cfg_holdoff);
        have_frame = 1;
        m_pend     = m_pend - 1;
      end
      if (m_edge) begin
        if (m_pend < DEPTH) begin
          m_pend = m_pend + 1;
          m_trig = m_trig + 1'b1;
        end else if (m_lost != '1) begin
          m_lost = m_lost + 1'b1;
        end
      end
      if (counter_clear) begin
        m_trig = '0;
        m_lost = '0;
      end
    end
  end

  // Compare process plus frame statistics, sampled on the falling edge.
  int en_cnt = 0, adc_cnt = 0, fs_cnt = 0, fe_cnt = 0;
  int first_en = -1, first_adc = -1, last_fe = -1;
  int fs_q[$];
  logic [23:0] act_v, exp_v;
  bit x_en, x_adc, x_fs, x_fe, x_busy;

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      x_en   = have_frame && (e_idx >= f_s) && (e_idx < f_s + f_n);
      x_adc  = have_frame && (e_idx >= f_s + 1) && (e_idx <= f_s + f_n);
      x_fs   = have_frame && (e_idx == f_s);
      x_fe   = have_frame && (e_idx == f_s + f_n);
      x_busy = (e_idx < busy_until) || (m_pend != 0);
      exp_v  = {x_en, x_adc, x_fs, x_fe, x_busy, PW'(m_pend), m_trig, m_lost};
      act_v  = {chip_read_clk_en, adc_read_en, frame_start, frame_end, busy,
                pending_count, trig_counter, lost_counter};
      check("cycle_outputs", 64'(act_v), 64'(exp_v));
      if (chip_read_clk_en) begin en_cnt++; if (first_en < 0) first_en = e_idx; end
      if (adc_read_en) begin adc_cnt++; if (first_adc < 0) first_adc = e_idx; end
      if (frame_start) begin fs_cnt++; fs_q.push_back(e_idx); end
      if (frame_end) begin fe_cnt++; last_fe = e_idx; end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive on the falling edge).
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_stats();
    en_cnt = 0; adc_cnt = 0; fs_cnt = 0; fe_cnt = 0;
    first_en = -1; first_adc = -1; last_fe = -1;
    fs_q.delete();
  endtask

  task automatic clear_counters();
    @(negedge clk); counter_clear = 1'b1;
    @(negedge clk); counter_clear = 1'b0;
  endtask

  // One-cycle pulse; k is the index of the clock edge that samples it.
  task automatic pulse(input logic [N_SRC-1:0] bits, output int k);
    @(negedge clk); trig_in = bits; k = e_idx + 1;
    @(negedge clk); trig_in = '0;
  endtask

  task automatic set_cfg(input int num, input int pre, input int hold);
    cfg_num_data  = NDW'(num);
    cfg_pre_delay = DW'(pre);
    cfg_holdoff   = DW'(hold);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((busy || adc_read_en) && c < budget);
    if (c >= budget) check("wait_idle_timeout", 64'(c), 64'(0));
    tick(2);
  endtask

  task automatic wait_en(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!chip_read_clk_en && c < budget);
    if (c >= budget) check("wait_en_timeout", 64'(c), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int k, k2;
    bit done;

    // Reset state
    tick(3);
    check("reset_en", 64'(chip_read_clk_en), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_pending", 64'(pending_count), 64'(0));
    check("reset_trig_counter", 64'(trig_counter), 64'(0));
    @(negedge clk); rstn = 1'b1;
    tick(2);

    // T1: single frame, 1280 reads, no delays
    trig_mask = 2'b01;
    set_cfg(1280, 0, 0);
    clear_counters();
    reset_stats();
    pulse(2'b01, k);
    wait_idle(3000);
    check("t1_first_en", 64'(first_en), 64'(k + 1));
    check("t1_first_adc", 64'(first_adc), 64'(k + 2));
    check("t1_en_cycles", 64'(en_cnt), 64'(1280));
    check("t1_adc_cycles", 64'(adc_cnt), 64'(1280));
    check("t1_frame_start", 64'(fs_cnt), 64'(1));
    check("t1_frame_end", 64'(fe_cnt), 64'(1));
    check("t1_frame_end_cycle", 64'(last_fe), 64'(k + 1281));
    check("t1_trig_counter", 64'(trig_counter), 64'(1));

    // T2: six edges inside one frame, queue depth 4
    set_cfg(20, 0, 3);
    clear_counters();
    reset_stats();
    repeat (6) pulse(2'b01, k);
    check("t2_pending_full", 64'(pending_count), 64'(DEPTH));
    check("t2_trig_counter", 64'(trig_counter), 64'(5));
    check("t2_lost_counter", 64'(lost_counter), 64'(1));
    wait_idle(2000);
    check("t2_frames", 64'(fs_cnt), 64'(5));
    check("t2_frame_ends", 64'(fe_cnt), 64'(5));
    check("t2_en_cycles", 64'(en_cnt), 64'(100));
    check("t2_busy_low", 64'(busy), 64'(0));

    // T3: simultaneous edges count once; masked source ignored
    set_cfg(4, 0, 0);
    trig_mask = 2'b11;
    clear_counters();
    reset_stats();
    pulse(2'b11, k);
    wait_idle(200);
    check("t3_simultaneous", 64'(trig_counter), 64'(1));
    check("t3_one_frame", 64'(fs_cnt), 64'(1));
    trig_mask = 2'b01;
    pulse(2'b10, k);
    tick(4);
    check("t3_masked_counter", 64'(trig_counter), 64'(1));
    check("t3_masked_busy", 64'(busy), 64'(0));
    check("t3_masked_frames", 64'(fs_cnt), 64'(1));

    // T4: pre_delay 3, holdoff 5, num_data 0 (treated as 1)
    set_cfg(0, 3, 5);
    clear_counters();
    reset_stats();
    pulse(2'b01, k);
    pulse(2'b01, k2);
    wait_idle(200);
    check("t4_en_rise", 64'(fs_q.size() > 0 ? fs_q[0] : -1), 64'(k + 4));
    check("t4_en_cycles", 64'(en_cnt), 64'(2));
    check("t4_frames", 64'(fs_cnt), 64'(2));
    check("t4_gap", 64'(fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1), 64'(10));

    // T5: reset during READ aborts the frame immediately
    set_cfg(200, 0, 0);
    clear_counters();
    reset_stats();
    pulse(2'b01, k);
    wait_en(50);
    tick(99);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_en", 64'(chip_read_clk_en), 64'(0));
    check("t5_rst_adc", 64'(adc_read_en), 64'(0));
    check("t5_rst_frame_end", 64'(frame_end), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_trig_counter", 64'(trig_counter), 64'(0));
    tick(3);
    check("t5_no_frame_end", 64'(fe_cnt), 64'(0));
    rstn = 1'b1;
    tick(2);
    reset_stats();
    pulse(2'b01, k);
    wait_idle(500);
    check("t5_full_frame_en", 64'(en_cnt), 64'(200));
    check("t5_full_frame_end", 64'(fe_cnt), 64'(1));
    check("t5_trig_counter", 64'(trig_counter), 64'(1));

    // T6: trig_counter wrap, lost_counter saturation, clear against an edge
    set_cfg(1, 0, 0);
    trig_mask = 2'b11;
    clear_counters();
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (trig_counter == '1) done = 1;
      else trig_in = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    trig_in = '0;
    if (!done) check("t6_reach_all_ones_timeout", 64'(trig_counter), 64'(8'hFF));
    wait_idle(100);
    check("t6_all_ones", 64'(trig_counter), 64'(8'hFF));
    pulse(2'b01, k);
    wait_idle(100);
    check("t6_wrap", 64'(trig_counter), 64'(0));
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      trig_in = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    @(negedge clk); trig_in = '0;
    wait_idle(100);
    check("t6_lost_saturated", 64'(lost_counter), 64'(8'hFF));
    reset_stats();
    @(negedge clk); trig_in = 2'b01; counter_clear = 1'b1;
    @(negedge clk); trig_in = '0; counter_clear = 1'b0;
    check("t6_clear_trig", 64'(trig_counter), 64'(0));
    check("t6_clear_lost", 64'(lost_counter), 64'(0));
    wait_idle(100);
    check("t6_clear_frame_runs", 64'(fs_cnt), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
